pipe_ctrl_unit: RTL and testbench

Central pipeline controller for the 5-stage core (IF, ID, EX, MEM, WB). Merges the load-use stall request from the hazard detector, EX-stage jump/branch redirects, multi-cycle divider occupancy and data-bus wait states into per-stage stall and flush controls. Tracks multi-cycle events with a small FSM and guards bus waits with a watchdog. Sits beside the hazard detector and drives the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipe_perf_cnt.sv | 30 +++
 rtl/pipe_ctrl_unit.sv | 176 +++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared constants for the pipeline controller (FSM encoding,
//            NOP word, default bus watchdog limit).
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_mem_wait = 2'd1;
    localparam logic [1:0] c_st_div_wait = 2'd2;

    // Bubble word inserted by flush consumers (addi x0, x0, 0)
    localparam logic [31:0] c_nop_insn = 32'h0000_0013;

    localparam int unsigned c_mem_timeout_def = 255;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic pc_redirect;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pipe_perf_cnt
// Brief    : Wrapping event counter with enable and synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign count = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : 5-stage pipeline stall/flush controller with bus watchdog.
//            Optional performance counters under PIPE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = c_mem_timeout_def,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             jump_flag,
    input  logic [31:0]      jump_addr,
    input  logic             div_start,
    input  logic             div_done,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             pc_redirect,
    output logic [31:0]      redirect_addr,
    output logic             bus_err,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    localparam logic [15:0] c_timeout    = 16'(MEM_TIMEOUT);
    localparam logic [15:0] c_timeout_m1 = 16'(MEM_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [15:0] r_wait_cnt;
    logic        r_bus_err;
    logic        w_bus_err_set;
    logic        w_mem_stall;
    logic        w_timeout;
    ctrl_t       w_ctl;

    assign w_mem_stall   = mem_req & ~mem_ack;
    assign w_timeout     = (r_wait_cnt == c_timeout);
    // Flag is registered so it appears in the exit cycle after the last wait
    assign w_bus_err_set = (r_state == c_st_mem_wait) && !w_timeout && !mem_ack
                           && (r_wait_cnt == c_timeout_m1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_st_run;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_bus_err <= w_bus_err_set;
            if ((r_state == c_st_mem_wait) && (w_next_state == c_st_mem_wait)) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_run: begin
                if (w_mem_stall) begin
                    w_next_state = c_st_mem_wait;
                end else if (!jump_flag && div_start) begin
                    w_next_state = c_st_div_wait;
                end
            end
            c_st_mem_wait: begin
                if (w_timeout || mem_ack) begin
                    w_next_state = c_st_run;
                end
            end
            c_st_div_wait: begin
                if (div_done) begin
                    w_next_state = w_mem_stall ? c_st_mem_wait : c_st_run;
                end
            end
            default: w_next_state = c_st_run;
        endcase
    end

    always_comb begin
        w_ctl = '0;
        case (r_state)
            c_st_run: begin
                if (w_mem_stall) begin
                    w_ctl.stall_pc     = 1'b1;
                    w_ctl.stall_if_id  = 1'b1;
                    w_ctl.stall_id_ex  = 1'b1;
                    w_ctl.stall_ex_mem = 1'b1;
                end else if (jump_flag) begin
                    w_ctl.pc_redirect  = 1'b1;
                    w_ctl.flush_if_id  = 1'b1;
                    w_ctl.flush_id_ex  = 1'b1;
                end else if (div_start) begin
                    w_ctl.stall_pc     = 1'b1;
                    w_ctl.stall_if_id  = 1'b1;
                    w_ctl.stall_id_ex  = 1'b1;
                end else if (load_use_stall) begin
                    w_ctl.stall_pc     = 1'b1;
                    w_ctl.stall_if_id  = 1'b1;
                    w_ctl.flush_id_ex  = 1'b1;
                end
            end
            c_st_mem_wait: begin
                if (!w_timeout && !mem_ack) begin
                    w_ctl.stall_pc     = 1'b1;
                    w_ctl.stall_if_id  = 1'b1;
                    w_ctl.stall_id_ex  = 1'b1;
                    w_ctl.stall_ex_mem = 1'b1;
                end
            end
            c_st_div_wait: begin
                // A bus wait coinciding with div_done carries straight into MEM_WAIT
                if (!div_done || w_mem_stall) begin
                    w_ctl.stall_pc     = 1'b1;
                    w_ctl.stall_if_id  = 1'b1;
                    w_ctl.stall_id_ex  = 1'b1;
                    w_ctl.stall_ex_mem = w_mem_stall;
                end
            end
            default: w_ctl = '0;
        endcase
    end

    assign stall_pc      = rst & w_ctl.stall_pc;
    assign stall_if_id   = rst & w_ctl.stall_if_id;
    assign stall_id_ex   = rst & w_ctl.stall_id_ex;
    assign stall_ex_mem  = rst & w_ctl.stall_ex_mem;
    assign flush_if_id   = rst & w_ctl.flush_if_id;
    assign flush_id_ex   = rst & w_ctl.flush_id_ex;
    assign pc_redirect   = rst & w_ctl.pc_redirect;
    assign redirect_addr = rst ? jump_addr : 32'h0;
    assign bus_err       = rst & r_bus_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] w_perf_stall;
    logic [CNT_W-1:0] w_perf_flush;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf_stall (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (stall_pc),
        .count (w_perf_stall)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf_flush (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (flush_id_ex),
        .count (w_perf_flush)
    );

    assign perf_stall_cnt = rst ? w_perf_stall : '0;
    assign perf_flush_cnt = rst ? w_perf_flush : '0;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Scoreboard bench for pipe_ctrl_unit (MEM_TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

    localparam int unsigned c_mt = 4;
    localparam int unsigned c_cw = 32;

    // Expected control vector: {stall_pc, stall_if_id, stall_id_ex,
    // stall_ex_mem, flush_if_id, flush_id_ex, pc_redirect, bus_err}
    localparam logic [7:0] c_e0   = 8'h00;
    localparam logic [7:0] c_eall = 8'hF0;
    localparam logic [7:0] c_elu  = 8'hC4;
    localparam logic [7:0] c_ejmp = 8'h0E;
    localparam logic [7:0] c_ediv = 8'hE0;
    localparam logic [7:0] c_ebe  = 8'h01;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit c_perf_en = 1'b1;
`else
    localparam bit c_perf_en = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            load_use_stall = 1'b0;
    logic            jump_flag = 1'b0;
    logic [31:0]     jump_addr = 32'h0;
    logic            div_start = 1'b0;
    logic            div_done = 1'b0;
    logic            mem_req = 1'b0;
    logic            mem_ack = 1'b0;
    logic            stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic            flush_if_id, flush_id_ex, pc_redirect, bus_err;
    logic [31:0]     redirect_addr;
    logic [c_cw-1:0] perf_stall_cnt, perf_flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.MEM_TIMEOUT(c_mt), .CNT_W(c_cw)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_use_stall (load_use_stall),
        .jump_flag      (jump_flag),
        .jump_addr      (jump_addr),
        .div_start      (div_start),
        .div_done       (div_done),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .stall_pc       (stall_pc),
        .stall_if_id    (stall_if_id),
        .stall_id_ex    (stall_id_ex),
        .stall_ex_mem   (stall_ex_mem),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .pc_redirect    (pc_redirect),
        .redirect_addr  (redirect_addr),
        .bus_err        (bus_err),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    wire [7:0] w_ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                        flush_if_id, flush_id_ex, pc_redirect, bus_err};

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [31:0] addr;
    } exp_t;

    exp_t r_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_exp_stall = 0;
    int   n_exp_flush = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (r_q.size() > 0) begin
            e = r_q.pop_front();
            check({e.tag, "/ctl"}, 64'(w_ctl), 64'(e.ctl));
            check({e.tag, "/addr"}, 64'(redirect_addr), 64'(e.addr));
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be in it
    task automatic cyc(input string tag, input logic r, input logic lu, input logic jf,
                       input logic [31:0] ja, input logic ds, input logic dd,
                       input logic mr, input logic ma, input logic [7:0] ec);
        exp_t e;
        rst = r; load_use_stall = lu; jump_flag = jf; jump_addr = ja;
        div_start = ds; div_done = dd; mem_req = mr; mem_ack = ma;
        e.tag  = tag;
        e.ctl  = ec;
        e.addr = r ? ja : 32'h0;
        r_q.push_back(e);
        if (!r) begin
            n_exp_stall = 0;
            n_exp_flush = 0;
        end else begin
            n_exp_stall += int'(ec[7]);
            n_exp_flush += int'(ec[2]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        // reset gates every output, even with requests present
        cyc("rst0",   0, 0, 1, 32'h0000_1234, 0, 0, 1, 0, c_e0);
        cyc("rst1",   0, 1, 0, 32'h0,         1, 0, 0, 0, c_e0);
        cyc("idle",   1, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, c_e0);
        // load-use
        cyc("lu",     1, 1, 0, 32'h0,         0, 0, 0, 0, c_elu);
        cyc("lu_end", 1, 0, 0, 32'h0,         0, 0, 0, 0, c_e0);
        // jump beats load-use
        cyc("jmp_lu", 1, 1, 1, 32'h0000_0100, 0, 0, 0, 0, c_ejmp);
        cyc("jmp_end",1, 0, 0, 32'h0000_0100, 0, 0, 0, 0, c_e0);
        // bus wait with ack; jump/div in the request cycle are ignored
        cyc("bus_req",1, 0, 1, 32'h0000_0200, 1, 0, 1, 0, c_eall);
        cyc("bus_w1", 1, 0, 0, 32'h0,         0, 0, 1, 0, c_eall);
        cyc("bus_w2", 1, 0, 0, 32'h0,         0, 0, 1, 0, c_eall);
        cyc("bus_ack",1, 0, 0, 32'h0,         0, 0, 1, 1, c_e0);
        cyc("bus_p1", 1, 0, 0, 32'h0,         0, 0, 0, 0, c_e0);
        cyc("bus_p2", 1, 1, 0, 32'h0,         0, 0, 0, 0, c_elu);
        // watchdog expiry
        cyc("wd_req", 1, 0, 0, 32'h0,         0, 0, 1, 0, c_eall);
        for (int i = 0; i < int'(c_mt); i++) begin
            cyc("wd_wait", 1, 0, 0, 32'h0,    0, 0, 1, 0, c_eall);
        end
        cyc("wd_exit",1, 0, 0, 32'h0,         0, 0, 0, 0, c_ebe);
        cyc("wd_post",1, 0, 0, 32'h0,         0, 0, 0, 0, c_e0);
        // divide with a concurrent bus wait
        cyc("div_go", 1, 1, 0, 32'h0,         1, 0, 0, 0, c_ediv);
        cyc("div_hld",1, 0, 0, 32'h0,         0, 0, 0, 0, c_ediv);
        cyc("div_m1", 1, 0, 0, 32'h0,         0, 0, 1, 0, c_eall);
        cyc("div_m2", 1, 0, 0, 32'h0,         0, 0, 1, 0, c_eall);
        cyc("div_ack",1, 0, 0, 32'h0,         0, 0, 1, 1, c_ediv);
        cyc("div_dn", 1, 0, 0, 32'h0,         0, 1, 0, 0, c_e0);
        cyc("div_pst",1, 1, 0, 32'h0,         0, 0, 0, 0, c_elu);
        // div_done and mem_ack together
        cyc("dd_go",  1, 0, 0, 32'h0,         1, 0, 0, 0, c_ediv);
        cyc("dd_ack", 1, 0, 0, 32'h0,         0, 1, 1, 1, c_e0);
        cyc("dd_pst", 1, 0, 1, 32'h0000_0300, 0, 0, 0, 0, c_ejmp);
        // reset one cycle before the watchdog would fire
        cyc("rw_req", 1, 0, 0, 32'h0,         0, 0, 1, 0, c_eall);
        for (int i = 0; i < int'(c_mt) - 1; i++) begin
            cyc("rw_wait", 1, 0, 0, 32'h0,    0, 0, 1, 0, c_eall);
        end
        cyc("rw_rst", 0, 0, 0, 32'h0,         0, 0, 1, 0, c_e0);
        cyc("rw_post",1, 0, 0, 32'h0,         0, 0, 0, 0, c_e0);
        for (int i = 0; i < 5; i++) begin
            cyc("perf_lu", 1, 1, 0, 32'h0,    0, 0, 0, 0, c_elu);
        end
        cyc("final",  1, 0, 0, 32'h0,         0, 0, 0, 0, c_e0);
        @(negedge clk);
        check("perf_stall", 64'(perf_stall_cnt), c_perf_en ? 64'(n_exp_stall) : 64'h0);
        check("perf_flush", 64'(perf_flush_cnt), c_perf_en ? 64'(n_exp_flush) : 64'h0);
        check("queue_drained", 64'(r_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
